// File: rtl/fp_mac_seq.sv
// Dot-product sequencer: issues FP16 operand pairs one at a time into an external
// FP16xFP16+FP32 MAC, feeds the running sum back as C and returns the FP32 result.
// Optional FP_MAC_SEQ_ZERO_SKIP_EN: pairs with a +/-0 operand are accepted without a MAC issue.
module fp_mac_seq #(
    parameter int          LAT  = 6,
    parameter logic [31:0] INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic [31:0] mac_c,
    input  logic [31:0] mac_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic [15:0] out_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CW = $clog2(LAT + 1);

    state_t          state, state_nx;
    logic [CW-1:0]   wait_cnt;
    logic            last_q;
    logic [31:0]     acc;
    logic            accept;
    logic            skip;
    logic            wait_done;

    assign accept    = in_valid & in_ready;
    assign wait_done = (wait_cnt == CW'(LAT));

`ifdef FP_MAC_SEQ_ZERO_SKIP_EN
    // Only signed zeros qualify; subnormals still go through the MAC.
    assign skip = (in_a[14:0] == 15'd0) || (in_b[14:0] == 15'd0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!skip)        state_nx = ISSUE;
                    else if (in_last) state_nx = DONE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (wait_done) state_nx = last_q ? DONE : IDLE;
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath. The MAC inputs are zero outside ISSUE so the Y produced in
    // those cycles is harmless; only the Y belonging to the issued pair is captured.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc       <= INIT;
            mac_a     <= 16'd0;
            mac_b     <= 16'd0;
            mac_c     <= 32'd0;
            out_y     <= INIT;
            out_count <= 16'd0;
            wait_cnt  <= '0;
            last_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        last_q <= in_last;
                        if (out_count != 16'hFFFF) out_count <= out_count + 16'd1;
                        if (!skip) begin
                            mac_a <= in_a;
                            mac_b <= in_b;
                            mac_c <= acc;
                        end else if (in_last) begin
                            out_y <= acc;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= CW'(1);
                    mac_a    <= 16'd0;
                    mac_b    <= 16'd0;
                    mac_c    <= 32'd0;
                end
                WAIT: begin
                    if (wait_done) begin
                        acc      <= mac_y;
                        wait_cnt <= '0;
                        if (last_q) out_y <= mac_y;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= INIT;
                        out_count <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fp_mac_seq.md
# fp_mac_seq

Dot-product sequencer that sits directly upstream of the FP16×FP16+FP32 MAC pipeline and consumes its result. It accepts a stream of FP16 operand pairs over a valid/ready handshake and issues one pair at a time into the MAC. It feeds the running FP32 sum back as the addend, captures the MAC output after the fixed pipeline latency, and presents the final FP32 dot product on a valid/ready result port.

## Interface
- LAT, 6, cycles from MAC inputs driven to MAC output valid; 1 input register plus 5 pipeline stages.
- INIT, 32'h0000_0000, FP32 value the accumulator starts from.

- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset. The instantiator drives the MAC's active-low reset as ~RESET.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  16  FP16 operand A.
- in_b  in  16  FP16 operand B.
- in_last  in  1  this pair ends the dot product.
- mac_a  out  16  to MAC A, registered.
- mac_b  out  16  to MAC B, registered.
- mac_c  out  32  to MAC C (running sum), registered.
- mac_y  in  32  MAC result Y.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_y  out  32  FP32 dot product.
- out_count  out  16  pairs consumed for this result, saturating at 16'hFFFF.

## Operation
- State machine states: IDLE, ISSUE, WAIT, DONE.
- Reset values:
  - state = IDLE.
  - acc = INIT.
  - mac_a, mac_b, mac_c = 0.
  - out_y = INIT.
  - out_count = 0.
  - wait counter = 0.
  - latched last flag = 0.
  - out_valid = 0.
  - in_ready = 1.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch in_a, in_b and in_last, increment out_count, and go to ISSUE.
  - Register mac_a = in_a, mac_b = in_b and mac_c = acc so that they are valid during ISSUE.
- ISSUE, 1 cycle:
  - The MAC samples mac_a, mac_b and mac_c at the end of this cycle.
  - Set wait counter = 1, clear mac_a, mac_b and mac_c to 0, and go to WAIT.
- WAIT:
  - in_ready = 0.
  - When counter == LAT, set acc <= mac_y. Then go to DONE if last was latched, otherwise go to IDLE.
  - Otherwise increment the counter.
- DONE:
  - out_valid = 1, out_y = acc.
  - in_ready = 0.
  - On out_ready, set acc <= INIT and out_count <= 0, and go to IDLE.
- Arithmetic: no FP arithmetic is performed in this block. All rounding and normalisation happen in the MAC; the sequencer only moves bits.
- MAC outputs in every non-ISSUE cycle are zeros; the garbage Y produced by those inputs is never captured.
- Boundaries:
  - in_last on the first pair: result after one MAC.
  - out_ready held high in DONE: out_valid high for exactly 1 cycle.
  - in_valid asserted during WAIT or DONE: ignored, and the pair is held by the source.
  - out_count saturates and does not wrap.
  - RESET asserted in any state: immediate return to reset values. An in-flight MAC result is discarded and no partial result is ever presented.

## Timing
- Inputs driven to the MAC during ISSUE cycle k produce Y that is stable during cycle k+LAT and captured at the end of that cycle.
- Accept edge to next in_ready = LAT+1 cycles.
- Throughput: 1 pair per LAT+2 cycles.
- Last accept edge to out_valid high = LAT+1 cycles.
- out_y and out_count are held stable while out_valid & !out_ready.
- All outputs are registered except in_ready and out_valid, which decode the state.

## Configuration
- FP_MAC_SEQ_ZERO_SKIP_EN.
  - Defined: in IDLE, a pair with in_a[14:0]==0 or in_b[14:0]==0 (±0 only, not subnormals) is accepted without issuing to the MAC.
    - acc is unchanged and out_count increments.
    - The state stays IDLE, or goes to DONE if in_last.
    - Zero pairs cost 1 cycle each.
  - Undefined: zero operands are issued to the MAC like any other pair.

## Test plan
- Pairs (0x3C00,0x4000), (0x4200,0x4000, last), INIT=0 -> out_y=0x41000000 (8.0), out_count=2. out_valid rises LAT+1 cycles after the second accept.
- Single pair (0x4200,0x4200, last) -> out_y=0x41100000 (9.0), out_count=1. mac_a is nonzero for exactly 1 cycle, and acc is captured on the LAT-th cycle after it.
- Zero skip, macro defined: (0x0000,0x4000), (0x3C00,0x3C00, last) -> out_y=0x3F800000, out_count=2. The MAC is issued exactly once. With the macro undefined, the result is the same but with 2 issues.
- Backpressure: out_ready low for 5 cycles in DONE -> out_y and out_count stable, and in_ready=0 with in_valid held high. After the out_ready handshake, the next dot product starts from INIT.
- RESET pulse during WAIT counter=3 -> all outputs at reset values the same cycle. A following single pair (0x3C00,0x3C00, last) yields 0x3F800000.
- Saturation: 65537 pairs of (0x0000,0x0000) with the macro defined -> out_count=0xFFFF, out_y=INIT.
